// File: rtl/trace_arbiter_pkg.sv
// Shared debug-trace types used by the trace arbiter and its FIFO.
// Define TRACE_HC_EN to add the hardware cycle-counter field (hc) to every record.
package DebugTypes;

    typedef enum logic [1:0] {
        REG   = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } TraceKind;

    typedef struct packed {
        TraceKind    kind;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] addr;
        logic [31:0] data;
`ifdef TRACE_HC_EN
        logic [31:0] hc;
`endif
    } TraceRecord;

    localparam logic [15:0] DROP_MAX = 16'hFFFF;

endpackage

// File: rtl/trace_fifo2w.sv
// Trace-record FIFO with two write ports and one read port per cycle.
// Write port 1 lands in the slot after port 0, so callers fill port 0 first.
module trace_fifo2w
    import DebugTypes::*;
#(
    parameter int DEPTH = 8,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr0_en,
    input  TraceRecord    wr0_rec,
    input  logic          wr1_en,
    input  TraceRecord    wr1_rec,
    input  logic          rd_en,
    output TraceRecord    head,
    output logic [CW-1:0] count
);

    TraceRecord    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr1_ptr;
    logic [1:0]    n_wr;
    logic          pop;

    assign wr1_ptr = wr_ptr + PW'(wr0_en);
    assign n_wr    = {1'b0, wr0_en} + {1'b0, wr1_en};
    assign pop     = rd_en && (count != '0);

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (wr0_en) mem[wr_ptr]  <= wr0_rec;
            if (wr1_en) mem[wr1_ptr] <= wr1_rec;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(n_wr);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + CW'(n_wr) - CW'(pop);
        end
    end

    // Empty slots may hold stale data, so an empty FIFO presents an all-zero head.
    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/trace_arbiter.sv
// Merges write-back and store trace events into one record stream, counting lost
// records and requesting a pipeline hold when the FIFO is nearly full. Macro: TRACE_HC_EN.
module trace_arbiter
    import DebugTypes::*;
#(
    parameter int DEPTH        = 8,
    parameter int STALL_MARGIN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wbValid,
    input  logic        wbIsLoad,
    input  logic [31:0] wbPc,
    input  logic [4:0]  wbRd,
    input  logic [31:0] wbData,
    input  logic [31:0] wbMemAddr,
    input  logic        stValid,
    input  logic [31:0] stPc,
    input  logic [31:0] stAddr,
    input  logic [31:0] stData,
    input  logic [31:0] hcIn,
    output logic        outValid,
    input  logic        outReady,
    output TraceRecord  outRec,
    output logic        stallReq,
    output logic [15:0] dropCount
);

    localparam int CW = $clog2(DEPTH) + 1;

    TraceRecord    wb_rec;
    TraceRecord    st_rec;
    TraceRecord    wr0_rec;
    logic [CW-1:0] count;
    logic [CW-1:0] free;
    logic [CW-1:0] next_count;
    logic [1:0]    req;
    logic [1:0]    accept;
    logic [1:0]    drop;
    logic [16:0]   drop_sum;
    logic          wr0_en;
    logic          wr1_en;
    logic          pop;

    always_comb begin
        wb_rec      = '0;
        wb_rec.kind = wbIsLoad ? LOAD : REG;
        wb_rec.pc   = wbPc;
        wb_rec.rd   = wbRd;
        wb_rec.addr = wbIsLoad ? wbMemAddr : 32'h0;
        wb_rec.data = wbData;
        st_rec      = '0;
        st_rec.kind = STORE;
        st_rec.pc   = stPc;
        st_rec.addr = stAddr;
        st_rec.data = stData;
`ifdef TRACE_HC_EN
        wb_rec.hc   = hcIn;
        st_rec.hc   = hcIn;
`endif
    end

`ifndef TRACE_HC_EN
    logic unused_hc;
    assign unused_hc = ^hcIn;
`endif

    // Free space uses the pre-pop count; the older write-back record takes the first slot.
    always_comb begin
        free       = CW'(DEPTH) - count;
        req        = {1'b0, wbValid} + {1'b0, stValid};
        accept     = (CW'(req) > free) ? free[1:0] : req;
        drop       = req - accept;
        wr0_en     = (accept != 2'd0);
        wr1_en     = (accept == 2'd2);
        wr0_rec    = wbValid ? wb_rec : st_rec;
        pop        = outValid && outReady;
        next_count = count + CW'(accept) - CW'(pop);
        drop_sum   = {1'b0, dropCount} + 17'(drop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dropCount <= '0;
            stallReq  <= 1'b0;
        end else begin
            dropCount <= drop_sum[16] ? DROP_MAX : drop_sum[15:0];
            stallReq  <= (CW'(DEPTH) - next_count) <= CW'(STALL_MARGIN);
        end
    end

    trace_fifo2w #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr0_en  (wr0_en),
        .wr0_rec (wr0_rec),
        .wr1_en  (wr1_en),
        .wr1_rec (st_rec),
        .rd_en   (pop),
        .head    (outRec),
        .count   (count)
    );

    assign outValid = (count != '0);

endmodule

// File: tb/tb_trace_arbiter.sv
// Self-checking bench for trace_arbiter: a table of per-cycle vectors with expected
// flags, plus a queue scoreboard of expected records and hand-written reset/hc sequences.
module tb_trace_arbiter;
    import DebugTypes::*;

    localparam int DEPTH        = 8;
    localparam int STALL_MARGIN = 2;
    localparam int NV           = 25;

    logic        clk = 1'b0;
    logic        rst;
    logic        wbValid;
    logic        wbIsLoad;
    logic [31:0] wbPc;
    logic [4:0]  wbRd;
    logic [31:0] wbData;
    logic [31:0] wbMemAddr;
    logic        stValid;
    logic [31:0] stPc;
    logic [31:0] stAddr;
    logic [31:0] stData;
    logic [31:0] hcIn;
    logic        outValid;
    logic        outReady;
    TraceRecord  outRec;
    logic        stallReq;
    logic [15:0] dropCount;

    typedef struct {
        logic        wb_v;
        logic        wb_ld;
        logic [31:0] wb_pc;
        logic [4:0]  wb_rd;
        logic [31:0] wb_data;
        logic [31:0] wb_addr;
        logic        st_v;
        logic [31:0] st_pc;
        logic [31:0] st_addr;
        logic [31:0] st_data;
        logic        rdy;
        logic        exp_valid;
        logic        exp_stall;
        logic [15:0] exp_drop;
    } vec_t;

    vec_t       vecs [NV];
    TraceRecord sb_q [$];
    int         drop_model;
    logic       stall_model;
    int         n_vec;
    int         n_fail;

    always #5 clk = ~clk;

    trace_arbiter #(
        .DEPTH        (DEPTH),
        .STALL_MARGIN (STALL_MARGIN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wbValid   (wbValid),
        .wbIsLoad  (wbIsLoad),
        .wbPc      (wbPc),
        .wbRd      (wbRd),
        .wbData    (wbData),
        .wbMemAddr (wbMemAddr),
        .stValid   (stValid),
        .stPc      (stPc),
        .stAddr    (stAddr),
        .stData    (stData),
        .hcIn      (hcIn),
        .outValid  (outValid),
        .outReady  (outReady),
        .outRec    (outRec),
        .stallReq  (stallReq),
        .dropCount (dropCount)
    );

    function automatic vec_t mkv(input logic wv, input logic ld, input logic [31:0] pc,
                                 input logic [4:0] rd, input logic [31:0] d, input logic [31:0] ma,
                                 input logic sv, input logic [31:0] spc, input logic [31:0] sa,
                                 input logic [31:0] sd, input logic rdy, input logic ev,
                                 input logic es, input logic [15:0] ed);
        vec_t v;
        v.wb_v = wv;  v.wb_ld = ld;  v.wb_pc = pc;  v.wb_rd = rd;  v.wb_data = d;
        v.wb_addr = ma;  v.st_v = sv;  v.st_pc = spc;  v.st_addr = sa;  v.st_data = sd;
        v.rdy = rdy;  v.exp_valid = ev;  v.exp_stall = es;  v.exp_drop = ed;
        return v;
    endfunction

    function automatic vec_t idle(input logic rdy, input logic ev, input logic es,
                                  input logic [15:0] ed);
        return mkv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rdy, ev, es, ed);
    endfunction

    function automatic TraceRecord exp_wb();
        TraceRecord r = '0;
        r.kind = wbIsLoad ? LOAD : REG;
        r.pc   = wbPc;
        r.rd   = wbRd;
        r.addr = wbIsLoad ? wbMemAddr : 32'h0;
        r.data = wbData;
`ifdef TRACE_HC_EN
        r.hc   = hcIn;
`endif
        return r;
    endfunction

    function automatic TraceRecord exp_st();
        TraceRecord r = '0;
        r.kind = STORE;
        r.pc   = stPc;
        r.addr = stAddr;
        r.data = stData;
`ifdef TRACE_HC_EN
        r.hc   = hcIn;
`endif
        return r;
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_rec(input string name, input TraceRecord act, input TraceRecord exp);
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        rst       = 1'b0;
        wbValid   = v.wb_v;
        wbIsLoad  = v.wb_ld;
        wbPc      = v.wb_pc;
        wbRd      = v.wb_rd;
        wbData    = v.wb_data;
        wbMemAddr = v.wb_addr;
        stValid   = v.st_v;
        stPc      = v.st_pc;
        stAddr    = v.st_addr;
        stData    = v.st_data;
        outReady  = v.rdy;
    endtask

    // Scoreboard: compares the DUT against the queue state from before this cycle's edge.
    task automatic check_output(input string tag);
        check_val({tag, ".outValid"}, 32'(outValid), 32'(sb_q.size() != 0));
        if (sb_q.size() != 0)
            check_rec({tag, outReady ? ".pop_rec" : ".head"}, outRec, sb_q[0]);
        check_val({tag, ".stallReq"}, 32'(stallReq), 32'(stall_model));
        check_val({tag, ".dropCount"}, 32'(dropCount), 32'(drop_model));
    endtask

    task automatic model_step();
        int         free;
        TraceRecord tmp;
        if (rst) begin
            sb_q.delete();
            drop_model  = 0;
            stall_model = 1'b0;
            return;
        end
        free = DEPTH - sb_q.size();
        if (outReady && sb_q.size() != 0) tmp = sb_q.pop_front();
        if (wbValid) begin
            if (free > 0) begin sb_q.push_back(exp_wb()); free--; end
            else drop_model++;
        end
        if (stValid) begin
            if (free > 0) begin sb_q.push_back(exp_st()); free--; end
            else drop_model++;
        end
        if (drop_model > 65535) drop_model = 65535;
        stall_model = (DEPTH - sb_q.size()) <= STALL_MARGIN;
    endtask

    task automatic run_cycle(input string tag);
        @(negedge clk);
        check_output(tag);
        model_step();
        @(posedge clk);
        #1;
        n_vec++;
    endtask

    initial begin
        n_vec = 0;
        n_fail = 0;
        hcIn = 32'h0;
        apply_stimulus(idle(0, 0, 0, 0));
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        sb_q.delete();
        drop_model  = 0;
        stall_model = 1'b0;

        // Single push, dual push with held head, load, store, overflow, full push/pop, drain.
        vecs[0]  = mkv(1, 0, 32'h10, 5, 32'h12345678, 32'h0, 0, 0, 0, 0, 1, 0, 0, 0);
        vecs[1]  = idle(1, 1, 0, 0);
        vecs[2]  = idle(1, 0, 0, 0);
        vecs[3]  = mkv(1, 0, 32'h14, 6, 32'hA5A50001, 32'h0,
                       1, 32'h18, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0);
        vecs[4]  = idle(0, 1, 0, 0);
        vecs[5]  = idle(0, 1, 0, 0);
        vecs[6]  = idle(0, 1, 0, 0);
        vecs[7]  = idle(1, 1, 0, 0);
        vecs[8]  = idle(1, 1, 0, 0);
        vecs[9]  = mkv(1, 1, 32'h20, 7, 32'h55, 32'h2000, 0, 0, 0, 0, 1, 0, 0, 0);
        vecs[10] = idle(1, 1, 0, 0);
        vecs[11] = mkv(0, 0, 0, 0, 0, 0, 1, 32'h24, 32'h300, 32'hCAFE, 1, 0, 0, 0);
        vecs[12] = idle(1, 1, 0, 0);
        vecs[13] = idle(1, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            vecs[14 + i] = mkv(1, 0, 32'h100 + 32'(i * 8), 5'(i + 1), 32'h1000 + 32'(i), 32'h0,
                               1, 32'h104 + 32'(i * 8), 32'h4000 + 32'(i * 4), 32'h2000 + 32'(i),
                               0, (i != 0), (i >= 3), 16'd0);
        vecs[19] = idle(0, 1, 1, 2);
        vecs[20] = mkv(1, 0, 32'h200, 10, 32'h77, 32'h0, 0, 0, 0, 0, 1, 1, 1, 2);
        vecs[21] = idle(0, 1, 1, 3);
        vecs[22] = idle(1, 1, 1, 3);
        vecs[23] = idle(1, 1, 1, 3);
        vecs[24] = idle(0, 1, 0, 3);

        for (int i = 0; i < NV; i++) begin
            apply_stimulus(vecs[i]);
            @(negedge clk);
            check_val($sformatf("vec%0d.valid", i), 32'(outValid), 32'(vecs[i].exp_valid));
            check_val($sformatf("vec%0d.stall", i), 32'(stallReq), 32'(vecs[i].exp_stall));
            check_val($sformatf("vec%0d.drop", i), 32'(dropCount), 32'(vecs[i].exp_drop));
            check_output($sformatf("vec%0d", i));
            model_step();
            @(posedge clk);
            #1;
            n_vec++;
        end

        // Reset with five records queued while a push and a pop are also requested.
        apply_stimulus(mkv(1, 0, 32'h40, 3, 32'h99, 32'h0, 1, 32'h44, 32'h8, 32'h9,
                           1, 1, 0, 3));
        rst = 1'b1;
        run_cycle("rst_mid");
        apply_stimulus(idle(0, 0, 0, 0));
        @(negedge clk);
        check_val("post_rst.outValid", 32'(outValid), 32'h0);
        check_val("post_rst.stallReq", 32'(stallReq), 32'h0);
        check_val("post_rst.dropCount", 32'(dropCount), 32'h0);
        check_val("post_rst.outRec_zero", 32'(outRec != '0), 32'h0);
        check_output("post_rst");
        model_step();
        @(posedge clk);
        #1;
        n_vec++;
        apply_stimulus(mkv(1, 0, 32'h48, 9, 32'hBEEF0009, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0));
        hcIn = 32'h000003E8;
        run_cycle("rst_push");
        hcIn = 32'h0;
        apply_stimulus(idle(1, 1, 0, 0));
        @(negedge clk);
        check_val("rst_push.head_valid", 32'(outValid), 32'h1);
        check_val("rst_push.head_pc", outRec.pc, 32'h48);
`ifdef TRACE_HC_EN
        check_val("hc_capture", outRec.hc, 32'h000003E8);
`endif
        check_output("rst_pop");
        model_step();
        @(posedge clk);
        #1;
        n_vec++;
        apply_stimulus(idle(1, 0, 0, 0));
        run_cycle("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
